// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and data accesses,
// one transaction at a time, DM first with a starvation guard that lets IF through.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);
  localparam int LW = $clog2(MEM_LATENCY + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [SW-1:0] starve_q, starve_d;
  logic we_q, we_d, owner_q, owner_d, busy_q, busy_d;
  logic mem_en_q, mem_en_d, mem_we_q, mem_we_d, if_ack_q, if_ack_d, dm_ack_q, dm_ack_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic if_wins;
  always_comb begin
    if_wins     = if_req && (!dm_req || starve_q == SW'(STARVE_LIMIT));
    state_d     = state_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    we_d        = we_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      IDLE: if (if_req || dm_req) begin
        state_d     = ISSUE;
        busy_d      = 1'b1;
        owner_d     = !if_wins;
        we_d        = !if_wins && dm_we;
        mem_en_d    = 1'b1;
        mem_we_d    = !if_wins && dm_we;
        mem_addr_d  = if_wins ? if_addr : dm_addr;
        mem_wdata_d = if_wins ? '0 : dm_wdata;
        // DM can only win over a pending IF below the limit, so the increment never overshoots
        starve_d    = (!if_wins && if_req) ? starve_q + SW'(1) : '0;
      end
      ISSUE: begin
        state_d = WAIT;
        lat_d   = LW'(MEM_LATENCY - 1);
      end
      WAIT: if (lat_q == '0) begin
        state_d    = RESP;
        if_ack_d   = !owner_q;
        dm_ack_d   = owner_q;
        if_rdata_d = !owner_q ? mem_rdata : if_rdata_q;
        dm_rdata_d = (owner_q && !we_q) ? mem_rdata : dm_rdata_q;
      end else begin
        lat_d = lat_q - LW'(1);
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      starve_q    <= '0;
      we_q        <= 1'b0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      we_q        <= we_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random IF/DM traffic against a transaction-timeline model of the arbiter.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, L = 3, SL = 4;
  logic clk = 1'b0, reset = 1'b0;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
  logic if_ack, dm_ack, mem_en, mem_we, busy, owner;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  int checks = 0, failures = 0;
  int cyc = 0, g = 0, starve = 0;
  bit act = 0, m_own = 0, m_we = 0, e_ifack = 0, e_dmack = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_if_rd = '0, m_dm_rd = '0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask
  // A transaction granted at the edge closing cycle g owns cycles g+1 (issue) .. g+L+2 (ack).
  task automatic check_outputs();
    int k;
    bit t;
    k = cyc - g;
    t = act && k >= 1 && k <= L + 2;
    e_ifack = t && k == L + 2 && !m_own;
    e_dmack = t && k == L + 2 && m_own;
    check("mem_en", 32'(mem_en), 32'(act && k == 1));
    check("mem_we", 32'(mem_we), 32'(act && k == 1 && m_we));
    check("mem_addr", mem_addr, m_addr);
    if (!act || m_own) check("mem_wdata", mem_wdata, m_wdata);
    check("busy", 32'(busy), 32'(t));
    check("if_ack", 32'(if_ack), 32'(e_ifack));
    check("dm_ack", 32'(dm_ack), 32'(e_dmack));
    check("if_rdata", if_rdata, m_if_rd);
    check("dm_rdata", dm_rdata, m_dm_rd);
    check("owner", 32'(owner), 32'(m_own));
  endtask
  task automatic model_step();
    bit ifw;
    if (act && cyc - g == L + 1) begin
      if (!m_own) m_if_rd = mem_rdata;
      else if (!m_we) m_dm_rd = mem_rdata;
    end
    if ((!act || cyc - g >= L + 3) && (if_req || dm_req)) begin
      ifw = if_req && (!dm_req || starve == SL);
      starve = (!ifw && if_req) ? ((starve < SL) ? starve + 1 : SL) : 0;
      act = 1;
      g = cyc;
      m_own = !ifw;
      m_we = !ifw && dm_we;
      m_addr = ifw ? if_addr : dm_addr;
      m_wdata = ifw ? '0 : dm_wdata;
    end
  endtask
  task automatic model_reset();
    act = 0; starve = 0; m_own = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_if_rd = '0; m_dm_rd = '0;
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask
  task automatic drive(input int p_if, input int p_dm, input bit jit);
    if (e_ifack) if_req = 1'b0;
    else if (!if_req && $urandom_range(1, 100) <= p_if) begin
      if_req = 1'b1;
      if_addr = $urandom;
    end
    if (e_dmack) dm_req = 1'b0;
    else if (!dm_req && $urandom_range(1, 100) <= p_dm) begin
      dm_req = 1'b1;
      dm_we = 1'($urandom_range(0, 1));
      dm_addr = $urandom;
      dm_wdata = $urandom;
    end
    if (jit && if_req && $urandom_range(0, 3) == 0) if_addr = $urandom;
    if (jit && dm_req && $urandom_range(0, 3) == 0) dm_addr = $urandom;
    mem_rdata = $urandom;
  endtask
  task automatic run(input int n, input int p_if, input int p_dm, input bit jit);
    for (int i = 0; i < n; i++) begin
      drive(p_if, p_dm, jit);
      tick();
    end
  endtask
  task automatic mid_reset(input int n);
    if_req = 1'b0;
    dm_req = 1'b0;
    run(L + 8, 0, 0, 0);
    if_req = 1'b1;
    if_addr = $urandom;
    tick();
    repeat (n) tick();
    #2 reset = 1'b0;
    #1;
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_if_ack", 32'(if_ack), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    if_req = 1'b0;
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b1;
    check_outputs();
  endtask
  initial begin
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h10;
    run(L + 5, 0, 0, 0);
    if_req = 1'b1; if_addr = 32'h0000_0abc;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    run(2 * (L + 3) + 3, 0, 0, 0);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h1234_5678;
    run(L + 5, 0, 0, 0);
    run(12 * (L + 3), 100, 100, 0);
    run(400, 30, 30, 1);
    mid_reset(1);
    if_req = 1'b1; if_addr = 32'h0000_0020;
    run(L + 5, 0, 0, 0);
    mid_reset(0);
    run(400, 100, 100, 1);
    run(400, 50, 20, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
